// File: rtl/phase_sequencer.sv
// Converts the run controller's clk1/clk2 phase strobes into one-cycle fetch/execute
// enables and handles halting on HLT, PC breakpoints or single-step.
module phase_sequencer #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ctl_reset,
  input  logic             ctl_enable,
  input  logic             clk1,
  input  logic             clk2,
  input  logic             resume,
  input  logic             halt_instr,
  input  logic [PC_W-1:0]  pc,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic             bp_en,
  input  logic             step_mode,
  output logic             fetch_en,
  output logic             exec_en,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count,
  output logic             phase_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_P1 = 2'd1,
    WAIT_P2 = 2'd2,
    HALTED  = 2'd3
  } state_t;

  state_t state;
  logic   clk1_q;
  logic   clk2_q;
  logic   resume_q;
  logic   clk1_rise;
  logic   clk2_rise;
  logic   resume_rise;
  logic   both_rise;

  function automatic logic halt_check(
    input logic            hlt,
    input logic            bpe,
    input logic [PC_W-1:0] cur_pc,
    input logic [PC_W-1:0] brk_pc,
    input logic            stp
  );
    return hlt | (bpe & (cur_pc == brk_pc)) | stp;
  endfunction

  assign clk1_rise   = clk1 & ~clk1_q;
  assign clk2_rise   = clk2 & ~clk2_q;
  assign resume_rise = resume & ~resume_q;
  assign both_rise   = clk1_rise & clk2_rise;

  // Edge-detect history tracks the strobes in every state, so a strobe already high
  // when the sequencer becomes active never counts as a fresh rise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      clk1_q      <= 1'b0;
      clk2_q      <= 1'b0;
      resume_q    <= 1'b0;
      fetch_en    <= 1'b0;
      exec_en     <= 1'b0;
      halted      <= 1'b0;
      instr_count <= '0;
      phase_err   <= 1'b0;
    end else begin
      clk1_q   <= clk1;
      clk2_q   <= clk2;
      resume_q <= resume;
      fetch_en <= 1'b0;
      exec_en  <= 1'b0;

      if (ctl_reset) begin
        state       <= IDLE;
        halted      <= 1'b0;
        instr_count <= '0;
        phase_err   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (ctl_enable) state <= WAIT_P1;
          end

          WAIT_P1: begin
            if (!ctl_enable) begin
              state <= IDLE;
            end else if (both_rise || clk2_rise) begin
              phase_err <= 1'b1;
            end else if (clk1_rise) begin
              fetch_en <= 1'b1;
              state    <= WAIT_P2;
            end
          end

          WAIT_P2: begin
            if (!ctl_enable) begin
              state <= IDLE;
            end else if (both_rise || clk1_rise) begin
              phase_err <= 1'b1;
            end else if (clk2_rise) begin
              exec_en     <= 1'b1;
              instr_count <= instr_count + 1'b1;
              // Halt qualifiers are sampled on the same edge that retires the instruction.
              if (halt_check(halt_instr, bp_en, pc, bp_addr, step_mode)) begin
                halted <= 1'b1;
                state  <= HALTED;
              end else begin
                state <= WAIT_P1;
              end
            end
          end

          HALTED: begin
            if (resume_rise) begin
              halted <= 1'b0;
              state  <= WAIT_P1;
            end
          end

          default: begin
            state  <= IDLE;
            halted <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: directed vector table, multi-cycle sequences and randomized
// stimulus against a behavioural model; a second instance with a 4-bit counter covers wrap.
module tb_phase_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, ctl_reset, ctl_enable, clk1, clk2, resume, halt_instr, bp_en, step_mode;
  logic [7:0] pc, bp_addr;
  logic       fetch_en, exec_en, halted, phase_err;
  logic [15:0] instr_count;
  logic       fetch_en4, exec_en4, halted4, phase_err4;
  logic [3:0] instr_count4;

  phase_sequencer #(.PC_W(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .ctl_reset(ctl_reset), .ctl_enable(ctl_enable),
    .clk1(clk1), .clk2(clk2), .resume(resume), .halt_instr(halt_instr),
    .pc(pc), .bp_addr(bp_addr), .bp_en(bp_en), .step_mode(step_mode),
    .fetch_en(fetch_en), .exec_en(exec_en), .halted(halted),
    .instr_count(instr_count), .phase_err(phase_err)
  );

  phase_sequencer #(.PC_W(8), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .ctl_reset(ctl_reset), .ctl_enable(ctl_enable),
    .clk1(clk1), .clk2(clk2), .resume(resume), .halt_instr(halt_instr),
    .pc(pc), .bp_addr(bp_addr), .bp_en(bp_en), .step_mode(step_mode),
    .fetch_en(fetch_en4), .exec_en(exec_en4), .halted(halted4),
    .instr_count(instr_count4), .phase_err(phase_err4)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Behavioural model: which strobe the core is waiting for, whether it is stopped,
  // and an unbounded retired count that each instance sees modulo its counter width.
  int          m_wait;      // 0 = inactive, 1 = expects fetch strobe, 2 = expects execute strobe
  bit          m_stopped, m_err, m_fetch, m_exec;
  int unsigned m_count;
  bit          prev1, prev2, prevr;

  task automatic model_reset();
    m_wait = 0; m_stopped = 0; m_err = 0; m_fetch = 0; m_exec = 0; m_count = 0;
    prev1 = 0; prev2 = 0; prevr = 0;
  endtask

  task automatic model_step();
    bit r1, r2, rr, stop_now;
    r1 = clk1 && !prev1;
    r2 = clk2 && !prev2;
    rr = resume && !prevr;
    stop_now = halt_instr || (bp_en && (pc == bp_addr)) || step_mode;
    m_fetch = 0;
    m_exec  = 0;
    if (ctl_reset) begin
      m_wait = 0; m_stopped = 0; m_count = 0; m_err = 0;
    end else if (m_stopped) begin
      if (rr) begin m_stopped = 0; m_wait = 1; end
    end else if (m_wait == 0) begin
      if (ctl_enable) m_wait = 1;
    end else if (!ctl_enable) begin
      m_wait = 0;
    end else if (r1 && r2) begin
      m_err = 1;
    end else if (m_wait == 1) begin
      if (r2) m_err = 1;
      else if (r1) begin m_fetch = 1; m_wait = 2; end
    end else begin
      if (r1) m_err = 1;
      else if (r2) begin
        m_exec = 1;
        m_count++;
        if (stop_now) m_stopped = 1;
        else m_wait = 1;
      end
    end
    prev1 = clk1; prev2 = clk2; prevr = resume;
  endtask

  task automatic compare_model();
    check("fetch_en",      32'(fetch_en),     32'(m_fetch));
    check("exec_en",       32'(exec_en),      32'(m_exec));
    check("halted",        32'(halted),       32'(m_stopped));
    check("phase_err",     32'(phase_err),    32'(m_err));
    check("instr_count",   32'(instr_count),  m_count % 65536);
    check("fetch_en_w4",   32'(fetch_en4),    32'(m_fetch));
    check("exec_en_w4",    32'(exec_en4),     32'(m_exec));
    check("halted_w4",     32'(halted4),      32'(m_stopped));
    check("phase_err_w4",  32'(phase_err4),   32'(m_err));
    check("instr_count_w4", 32'(instr_count4), m_count % 16);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic run_pair();
    clk1 = 1'b1; repeat (3) cycle();
    clk1 = 1'b0; repeat (2) cycle();
    clk2 = 1'b1; repeat (3) cycle();
    clk2 = 1'b0; repeat (2) cycle();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_fetch"},  32'(fetch_en),     32'd0);
    check({tag, "_exec"},   32'(exec_en),      32'd0);
    check({tag, "_halted"}, 32'(halted),       32'd0);
    check({tag, "_count"},  32'(instr_count),  32'd0);
    check({tag, "_err"},    32'(phase_err),    32'd0);
    check({tag, "_count4"}, 32'(instr_count4), 32'd0);
  endtask

  typedef struct {
    int c1, c2, res, hlt, bpen, step, pc, bpa, en, crst, hold;
    int ef, ee, eh, ec, eerr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int c1, int c2, int res, int hlt, int bpen, int step, int pcv,
                              int bpa, int en, int crst, int hold,
                              int ef, int ee, int eh, int ec, int eerr);
    vec_t v;
    v.c1 = c1; v.c2 = c2; v.res = res; v.hlt = hlt; v.bpen = bpen; v.step = step;
    v.pc = pcv; v.bpa = bpa; v.en = en; v.crst = crst; v.hold = hold;
    v.ef = ef; v.ee = ee; v.eh = eh; v.ec = ec; v.eerr = eerr;
    return v;
  endfunction

  initial begin
    // c1 c2 res hlt bpen step pc bpa en crst hold | fetch exec halted count err
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1,0,2, 0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,1,0,4, 1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1,0,2, 0,0,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,0,1,0,4, 0,1,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1,0,2, 0,0,0,1,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,1,0,4, 1,0,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1,0,2, 0,0,0,1,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,0,1,0,4, 0,1,0,2,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1,0,2, 0,0,0,2,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,1,0,4, 1,0,0,2,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1,0,2, 0,0,0,2,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,0,1,0,4, 0,1,0,3,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1,0,2, 0,0,0,3,0));
    // soft reset, then HLT on the second execute
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1,1,2, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1,0,2, 0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,1,0,4, 1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1,0,2, 0,0,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,0,1,0,4, 0,1,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1,0,2, 0,0,0,1,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,1,0,4, 1,0,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1,0,2, 0,0,0,1,0));
    tbl.push_back(mk(0,1,0,1,0,0,0,0,1,0,4, 0,1,1,2,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1,0,2, 0,0,1,2,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,1,0,4, 0,0,1,2,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1,0,2, 0,0,1,2,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,0,1,0,4, 0,0,1,2,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1,0,2, 0,0,1,2,0));
    tbl.push_back(mk(0,0,1,0,0,0,0,0,1,0,2, 0,0,0,2,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1,0,2, 0,0,0,2,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,1,0,4, 1,0,0,2,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1,0,2, 0,0,0,2,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,0,1,0,4, 0,1,0,3,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1,0,2, 0,0,0,3,0));
    // protocol violations
    tbl.push_back(mk(0,1,0,0,0,0,0,0,1,0,4, 0,0,0,3,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1,0,2, 0,0,0,3,1));
    tbl.push_back(mk(0,1,0,0,0,0,0,0,1,0,4, 0,0,0,3,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1,0,2, 0,0,0,3,1));
    tbl.push_back(mk(1,1,0,0,0,0,0,0,1,0,4, 0,0,0,3,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1,0,2, 0,0,0,3,1));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,1,0,4, 1,0,0,3,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1,0,2, 0,0,0,3,1));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,1,0,4, 0,0,0,3,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1,0,2, 0,0,0,3,1));
    tbl.push_back(mk(0,1,0,0,0,0,0,0,1,0,4, 0,1,0,4,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1,0,2, 0,0,0,4,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1,1,2, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1,0,2, 0,0,0,0,0));
    // breakpoint at 0x05 with pc stepping 3,4,5
    tbl.push_back(mk(1,0,0,0,1,0,3,5,1,0,4, 1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,0,3,5,1,0,2, 0,0,0,0,0));
    tbl.push_back(mk(0,1,0,0,1,0,3,5,1,0,4, 0,1,0,1,0));
    tbl.push_back(mk(0,0,0,0,1,0,3,5,1,0,2, 0,0,0,1,0));
    tbl.push_back(mk(1,0,0,0,1,0,4,5,1,0,4, 1,0,0,1,0));
    tbl.push_back(mk(0,0,0,0,1,0,4,5,1,0,2, 0,0,0,1,0));
    tbl.push_back(mk(0,1,0,0,1,0,4,5,1,0,4, 0,1,0,2,0));
    tbl.push_back(mk(0,0,0,0,1,0,4,5,1,0,2, 0,0,0,2,0));
    tbl.push_back(mk(1,0,0,0,1,0,5,5,1,0,4, 1,0,0,2,0));
    tbl.push_back(mk(0,0,0,0,1,0,5,5,1,0,2, 0,0,0,2,0));
    tbl.push_back(mk(0,1,0,0,1,0,5,5,1,0,4, 0,1,1,3,0));
    tbl.push_back(mk(0,0,0,0,1,0,5,5,1,0,2, 0,0,1,3,0));
    tbl.push_back(mk(0,0,1,0,1,0,5,5,1,0,2, 0,0,0,3,0));
    tbl.push_back(mk(0,0,0,0,1,0,5,5,1,0,2, 0,0,0,3,0));
    // same address with the breakpoint disabled
    tbl.push_back(mk(1,0,0,0,0,0,5,5,1,0,4, 1,0,0,3,0));
    tbl.push_back(mk(0,0,0,0,0,0,5,5,1,0,2, 0,0,0,3,0));
    tbl.push_back(mk(0,1,0,0,0,0,5,5,1,0,4, 0,1,0,4,0));
    tbl.push_back(mk(0,0,0,0,0,0,5,5,1,0,2, 0,0,0,4,0));
    // single step
    tbl.push_back(mk(1,0,0,0,0,1,0,0,1,0,4, 1,0,0,4,0));
    tbl.push_back(mk(0,0,0,0,0,1,0,0,1,0,2, 0,0,0,4,0));
    tbl.push_back(mk(0,1,0,0,0,1,0,0,1,0,4, 0,1,1,5,0));
    tbl.push_back(mk(0,0,0,0,0,1,0,0,1,0,2, 0,0,1,5,0));
    tbl.push_back(mk(0,0,1,0,0,1,0,0,1,0,2, 0,0,0,5,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1,0,2, 0,0,0,5,0));

    reset = 1'b0; ctl_reset = 1'b0; ctl_enable = 1'b0; clk1 = 1'b0; clk2 = 1'b0;
    resume = 1'b0; halt_instr = 1'b0; bp_en = 1'b0; step_mode = 1'b0;
    pc = 8'h00; bp_addr = 8'h00;
    model_reset();
    @(posedge clk); #1;
    check_all_zero("reset_state");
    reset = 1'b1;
    cycle();

    foreach (tbl[i]) begin
      clk1 = (tbl[i].c1 != 0); clk2 = (tbl[i].c2 != 0); resume = (tbl[i].res != 0);
      halt_instr = (tbl[i].hlt != 0); bp_en = (tbl[i].bpen != 0);
      step_mode = (tbl[i].step != 0); pc = 8'(tbl[i].pc); bp_addr = 8'(tbl[i].bpa);
      ctl_enable = (tbl[i].en != 0); ctl_reset = (tbl[i].crst != 0);
      cycle();
      check($sformatf("vec%0d_fetch", i),  32'(fetch_en),    tbl[i].ef);
      check($sformatf("vec%0d_exec", i),   32'(exec_en),     tbl[i].ee);
      check($sformatf("vec%0d_halted", i), 32'(halted),      tbl[i].eh);
      check($sformatf("vec%0d_count", i),  32'(instr_count), tbl[i].ec);
      check($sformatf("vec%0d_err", i),    32'(phase_err),   tbl[i].eerr);
      repeat (tbl[i].hold - 1) cycle();
    end

    // Step mode: four instructions, each released by a resume pulse
    ctl_reset = 1'b1; cycle();
    ctl_reset = 1'b0; cycle();
    step_mode = 1'b1;
    for (int k = 0; k < 4; k++) begin
      run_pair();
      check($sformatf("step%0d_halted", k), 32'(halted), 32'd1);
      resume = 1'b1; repeat (2) cycle();
      resume = 1'b0; repeat (2) cycle();
    end
    check("step_count", 32'(instr_count), 32'd4);
    check("step_released", 32'(halted), 32'd0);
    step_mode = 1'b0;

    // Counter wrap: 17 instructions on a 4-bit counter leaves 1
    ctl_reset = 1'b1; cycle();
    ctl_reset = 1'b0; cycle();
    repeat (17) run_pair();
    check("wrap_count4", 32'(instr_count4), 32'd1);
    check("wrap_count16", 32'(instr_count), 32'd17);

    // Asynchronous reset while waiting for the execute strobe
    clk1 = 1'b1; repeat (3) cycle();
    clk1 = 1'b0; cycle();
    check("pre_async_count", 32'(instr_count), 32'd17);
    #2 reset = 1'b0;
    #1 check_all_zero("async_reset");
    model_reset();
    @(posedge clk); #1;
    check_all_zero("async_hold");
    reset = 1'b1;
    repeat (3) cycle();

    // Randomized run against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(3) == 0) clk1 = ~clk1;
      if ($urandom_range(3) == 0) clk2 = ~clk2;
      if ($urandom_range(7) == 0) resume = ~resume;
      ctl_enable = ($urandom_range(19) != 0);
      ctl_reset  = ($urandom_range(79) == 0);
      halt_instr = ($urandom_range(7) == 0);
      step_mode  = ($urandom_range(15) == 0);
      bp_en      = 1'($urandom_range(1));
      pc         = 8'($urandom_range(7));
      bp_addr    = 8'h05;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
